// File: rtl/maze_path_checker.sv
// Replays a 17x17 maze solver's direction stream against the snooped maze bitmap and reports
// one pass/fail result per maze. Define PATH_CHECK_REVISIT_EN to add revisit detection.
module maze_path_checker #(
    parameter int unsigned MAZE_WIDTH = 17,
    parameter int unsigned CNT_WIDTH  = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 maze_valid_i,
    input  logic                 maze_bit_i,
    input  logic                 dir_valid_i,
    input  logic [1:0]           dir_i,
    output logic                 result_valid_o,
    output logic                 pass_o,
    output logic [1:0]           err_code_o,
    output logic [CNT_WIDTH-1:0] err_step_o,
    output logic [CNT_WIDTH-1:0] step_cnt_o
);

    localparam int unsigned NumCells = MAZE_WIDTH * MAZE_WIDTH;
    localparam int unsigned PosW     = $clog2(MAZE_WIDTH);

    localparam logic [PosW-1:0]      PosMax  = PosW'(MAZE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax  = '1;
    localparam logic [CNT_WIDTH-1:0] CellLim = CNT_WIDTH'(NumCells);
    localparam logic [1:0]           ErrNone = 2'd0;
    localparam logic [1:0]           ErrWall = 2'd1;
    localparam logic [1:0]           ErrOob  = 2'd2;
`ifdef PATH_CHECK_REVISIT_EN
    localparam logic [1:0]           ErrRevisit = 2'd3;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StTrack,
        StReport
    } state_e;

    state_e                 state_q, state_d;
    logic [NumCells-1:0]    maze_q, maze_d;
    logic [CNT_WIDTH-1:0]   load_idx_q, load_idx_d;
    logic [PosW-1:0]        row_q, row_d, col_q, col_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [1:0]             err_q, err_d;
    logic [CNT_WIDTH-1:0]   err_step_q, err_step_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_pass_q, res_pass_d;
    logic [1:0]             res_code_q, res_code_d;
    logic [CNT_WIDTH-1:0]   res_step_q, res_step_d;
    logic [CNT_WIDTH-1:0]   res_cnt_q, res_cnt_d;
`ifdef PATH_CHECK_REVISIT_EN
    logic [NumCells-1:0]    visited_q, visited_d;
    logic [NumCells-1:0]    vis_b, s_vis;
`endif

    // Single-step evaluation; in WAIT it starts from a fresh track context.
    logic                   start_track;
    logic [PosW-1:0]        row_b, col_b, trow, tcol, s_row, s_col;
    logic [CNT_WIDTH-1:0]   cnt_b, err_step_b, s_cnt, s_err_step, tidx;
    logic [1:0]             err_b, s_err;
    logic                   oob;

    always_comb begin
        start_track = (state_q == StWait);
        row_b       = start_track ? '0 : row_q;
        col_b       = start_track ? '0 : col_q;
        cnt_b       = start_track ? '0 : cnt_q;
        err_b       = start_track ? ErrNone : err_q;
        err_step_b  = start_track ? '0 : err_step_q;
`ifdef PATH_CHECK_REVISIT_EN
        vis_b       = start_track ? NumCells'(1) : visited_q;
        s_vis       = vis_b;
`endif
        trow = row_b;
        tcol = col_b;
        oob  = 1'b0;
        unique case (dir_i)
            2'd0: begin
                oob  = (col_b == PosMax);
                tcol = col_b + 1'b1;
            end
            2'd1: begin
                oob  = (row_b == PosMax);
                trow = row_b + 1'b1;
            end
            2'd2: begin
                oob  = (col_b == '0);
                tcol = col_b - 1'b1;
            end
            2'd3: begin
                oob  = (row_b == '0);
                trow = row_b - 1'b1;
            end
        endcase
        tidx = CNT_WIDTH'(trow) * CNT_WIDTH'(MAZE_WIDTH) + CNT_WIDTH'(tcol);

        s_cnt      = (cnt_b == CntMax) ? cnt_b : cnt_b + 1'b1;
        s_row      = row_b;
        s_col      = col_b;
        s_err      = err_b;
        s_err_step = err_step_b;
        if (err_b == ErrNone) begin
            if (oob) begin
                s_err      = ErrOob;
                s_err_step = s_cnt;
            end else if (!maze_q[tidx]) begin
                s_err      = ErrWall;
                s_err_step = s_cnt;
            end
`ifdef PATH_CHECK_REVISIT_EN
            else if (vis_b[tidx]) begin
                s_err      = ErrRevisit;
                s_err_step = s_cnt;
            end
`endif
            else begin
                s_row = trow;
                s_col = tcol;
`ifdef PATH_CHECK_REVISIT_EN
                s_vis[tidx] = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        maze_d      = maze_q;
        load_idx_d  = load_idx_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        err_step_d  = err_step_q;
        res_valid_d = 1'b0;
        res_pass_d  = res_pass_q;
        res_code_d  = res_code_q;
        res_step_d  = res_step_q;
        res_cnt_d   = res_cnt_q;
`ifdef PATH_CHECK_REVISIT_EN
        visited_d   = visited_q;
`endif
        unique case (state_q)
            StIdle, StWait: begin
                if (maze_valid_i) begin
                    maze_d     = '0;
                    maze_d[0]  = maze_bit_i;
                    load_idx_d = CNT_WIDTH'(1);
                    state_d    = StLoad;
`ifdef PATH_CHECK_REVISIT_EN
                    visited_d  = '0;
`endif
                end else if (dir_valid_i && (state_q == StWait)) begin
                    row_d      = s_row;
                    col_d      = s_col;
                    cnt_d      = s_cnt;
                    err_d      = s_err;
                    err_step_d = s_err_step;
                    state_d    = StTrack;
`ifdef PATH_CHECK_REVISIT_EN
                    visited_d  = s_vis;
`endif
                end
            end
            StLoad: begin
                if (maze_valid_i) begin
                    // Bits past the last cell are dropped.
                    if (load_idx_q < CellLim) begin
                        maze_d[load_idx_q] = maze_bit_i;
                        load_idx_d         = load_idx_q + 1'b1;
                    end
                end else begin
                    state_d = StWait;
                end
            end
            StTrack: begin
                if (dir_valid_i) begin
                    row_d      = s_row;
                    col_d      = s_col;
                    cnt_d      = s_cnt;
                    err_d      = s_err;
                    err_step_d = s_err_step;
`ifdef PATH_CHECK_REVISIT_EN
                    visited_d  = s_vis;
`endif
                end else begin
                    res_valid_d = 1'b1;
                    res_pass_d  = (err_q == ErrNone) && (row_q == PosMax) && (col_q == PosMax);
                    res_code_d  = err_q;
                    res_step_d  = err_step_q;
                    res_cnt_d   = cnt_q;
                    state_d     = StReport;
                end
            end
            StReport: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            maze_q      <= '0;
            load_idx_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            err_q       <= ErrNone;
            err_step_q  <= '0;
            res_valid_q <= 1'b0;
            res_pass_q  <= 1'b0;
            res_code_q  <= ErrNone;
            res_step_q  <= '0;
            res_cnt_q   <= '0;
`ifdef PATH_CHECK_REVISIT_EN
            visited_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            maze_q      <= maze_d;
            load_idx_q  <= load_idx_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_step_q  <= err_step_d;
            res_valid_q <= res_valid_d;
            res_pass_q  <= res_pass_d;
            res_code_q  <= res_code_d;
            res_step_q  <= res_step_d;
            res_cnt_q   <= res_cnt_d;
`ifdef PATH_CHECK_REVISIT_EN
            visited_q   <= visited_d;
`endif
        end
    end

    assign result_valid_o = res_valid_q;
    assign pass_o         = res_pass_q;
    assign err_code_o     = res_code_q;
    assign err_step_o     = res_step_q;
    assign step_cnt_o     = res_cnt_q;

endmodule
